// File: rtl/dbg_bus_ctrl.sv
// rtl/dbg_bus_ctrl.sv - memory/register port arbiter between core pipeline and debug module
module dbg_bus_ctrl #(
  parameter int TIMEOUT_BITS = 8,
  parameter int ADDR_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dbg_op_req_i,
  input  logic                 dbg_halt_req_i,
  input  logic                 dbg_mem_we_i,
  input  logic [ADDR_BITS-1:0] dbg_mem_addr_i,
  input  logic [31:0]          dbg_mem_wdata_i,
  input  logic                 dbg_reg_we_i,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic [ADDR_BITS-1:0] core_addr_i,
  input  logic [31:0]          core_wdata_i,
  input  logic                 core_idle_i,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 rf_dbg_we_o,
  output logic                 core_hold_o,
  output logic                 core_gnt_o,
  output logic                 dbg_gnt_o,
  output logic                 timeout_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_BITS-1:0] CNT_ONE = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [TIMEOUT_BITS-1:0] drain_cnt;
  logic                    any_req;
  logic                    drain_expired;

  assign any_req = dbg_op_req_i | dbg_halt_req_i;

  // Drain gives up waiting only when the core is still busy; an idle core in the
  // same cycle wins so the grant is reported as clean rather than forced.
  assign drain_expired = (state == ST_DRAIN) && any_req && !core_idle_i &&
                         (drain_cnt == CNT_MAX);

  // Next-state selection; a request withdrawn while draining skips the grant.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!any_req)                  state_nxt = ST_RELEASE;
        else if (core_idle_i)          state_nxt = ST_GRANT;
        else if (drain_cnt == CNT_MAX) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (!any_req) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Drain-wait counter: runs only while draining, zero everywhere else so every
  // new drain starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 drain_cnt <= '0;
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt + CNT_ONE;
    else                        drain_cnt <= '0;
  end

  // Sticky timeout flag: describes the most recent grant, cleared when a new request starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            timeout_o <= 1'b0;
    else if ((state == ST_IDLE) && any_req) timeout_o <= 1'b0;
    else if (drain_expired)                 timeout_o <= 1'b1;
  end

  // Ownership flags registered from the next state so they change in step with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_hold_o <= 1'b0;
      core_gnt_o  <= 1'b1;
      dbg_gnt_o   <= 1'b0;
    end else begin
      core_hold_o <= (state_nxt == ST_DRAIN) || (state_nxt == ST_GRANT);
      core_gnt_o  <= (state_nxt == ST_IDLE);
      dbg_gnt_o   <= (state_nxt == ST_GRANT);
    end
  end

  // Memory port mux; an ungranted side never reaches the RAM, and RELEASE/DRAIN park the port.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dbg_gnt_o) begin
      mem_we_o    = dbg_mem_we_i;
      mem_addr_o  = dbg_mem_addr_i;
      mem_wdata_o = dbg_mem_wdata_i;
    end else if (core_gnt_o) begin
      mem_we_o    = core_req_i & core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end
  end

  assign rf_dbg_we_o = dbg_reg_we_i & dbg_gnt_o;

endmodule

// File: doc/dbg_bus_ctrl.md
# dbg_bus_ctrl

Controller that shares the core's data-memory port and register-file debug write port between the CPU pipeline and the JTAG debug module. On a debug operation or halt request it stalls the core, waits for the core's bus to go idle (bounded by a timeout), hands the memory/register port to the debug side, and returns ownership when the debug side releases. It sits between the debug top-level (JTAG transport plus debug module) and the core/RAM interconnect.

## Interface
- TIMEOUT_BITS, 8: width of the drain-wait counter; timeout after 2^TIMEOUT_BITS-1 cycles.
- ADDR_BITS, 32: memory address width.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- dbg_op_req_i  in  1  debug module access request (level)
- dbg_halt_req_i  in  1  debug module halt request (level)
- dbg_mem_we_i  in  1  debug memory write enable
- dbg_mem_addr_i  in  ADDR_BITS  debug memory address
- dbg_mem_wdata_i  in  32  debug memory write data
- dbg_reg_we_i  in  1  debug register write enable
- core_req_i  in  1  core memory access valid
- core_we_i  in  1  core memory write enable
- core_addr_i  in  ADDR_BITS  core memory address
- core_wdata_i  in  32  core memory write data
- core_idle_i  in  1  core has no outstanding memory transaction
- mem_we_o  out  1  to RAM: write enable
- mem_addr_o  out  ADDR_BITS  to RAM: address
- mem_wdata_o  out  32  to RAM: write data
- rf_dbg_we_o  out  1  gated debug register-file write enable
- core_hold_o  out  1  stall request to core pipeline
- core_gnt_o  out  1  core owns memory port
- dbg_gnt_o  out  1  debug side owns memory/register port
- timeout_o  out  1  sticky: last grant was forced by timeout

## Operation
- FSM states: IDLE, DRAIN, GRANT, RELEASE. Reset state IDLE.
- IDLE: core owns port. If dbg_op_req_i | dbg_halt_req_i → DRAIN; counter cleared, timeout_o cleared.
- DRAIN: core_hold_o=1; counter increments each cycle. core_idle_i=1 → GRANT. Counter reaching 2^TIMEOUT_BITS-1 with core_idle_i=0 → GRANT, timeout_o set. core_idle_i takes priority over timeout in the same cycle (timeout_o stays 0). If both requests drop in DRAIN → RELEASE.
- GRANT: core_hold_o=1, dbg_gnt_o=1. Stays while dbg_op_req_i | dbg_halt_req_i. Both low → RELEASE.
- RELEASE: core_hold_o=0, no grant to either side, one cycle; → IDLE unconditionally (a request seen in RELEASE is taken from IDLE next cycle).
- Port mux: dbg_gnt_o=1 → mem_* driven from dbg_mem_*; core_gnt_o=1 → mem_we_o=core_req_i&core_we_i, addr/wdata from core; otherwise mem_we_o=0, addr/wdata 0.
- rf_dbg_we_o = dbg_reg_we_i & dbg_gnt_o. Debug writes outside GRANT are dropped.
- Read data is not muxed; RAM read data fans out to both masters.

## Timing
- Reset values: core_hold_o=0, core_gnt_o=1, dbg_gnt_o=0, timeout_o=0, mem_we_o=core_req_i&core_we_i (combinational from core), rf_dbg_we_o=0.
- core_hold_o, core_gnt_o, dbg_gnt_o, timeout_o are registered (decoded from state register); mem_* and rf_dbg_we_o are combinational from grant registers and inputs.
- Request at edge N (sampled) → core_hold_o=1, core_gnt_o=0 after edge N.
- core_idle_i sampled high in DRAIN at edge M → dbg_gnt_o=1 after edge M. Minimum request-to-grant latency: 2 cycles.
- Timeout: grant asserted at most 2^TIMEOUT_BITS cycles after entering DRAIN.
- Release: requests low at edge K in GRANT → dbg_gnt_o=0 after K; core_gnt_o=1, core_hold_o=0 after K+1.
- Never dbg_gnt_o & core_gnt_o simultaneously; never mem_we_o from a non-granted side.
- rst_n low mid-GRANT: immediately IDLE, core_gnt_o=1, dbg_gnt_o=0, timeout_o=0, counter cleared.

## Test plan
- Reset with core_req_i=1, core_we_i=1, core_addr_i=0x100 → core_gnt_o=1, mem_we_o=1, mem_addr_o=0x100, core_hold_o=0.
- dbg_op_req_i=1, core_idle_i=1 → core_hold_o=1 after 1 edge, dbg_gnt_o=1 after 2; dbg_mem_addr_i=0x200 with dbg_mem_we_i=1 → mem_addr_o=0x200, mem_we_o=1; core_we_i=1 ignored.
- TIMEOUT_BITS=3, core_idle_i=0, dbg_halt_req_i=1 → dbg_gnt_o=1 after 8 cycles of DRAIN, timeout_o=1; next request with core_idle_i=1 clears timeout_o.
- core_idle_i rises on the same cycle counter hits 7 → GRANT with timeout_o=0.
- dbg_reg_we_i=1 in IDLE → rf_dbg_we_o=0; in GRANT → rf_dbg_we_o=1; drop requests → 1 RELEASE cycle with both grants 0, then core_gnt_o=1.
- Assert rst_n=0 during GRANT with dbg_mem_we_i=1 → mem_we_o follows core, dbg_gnt_o=0 immediately.
